serial_pattern_gen: RTL
=======================

// Module: serial_pattern_gen
// PURPOSE
//  Upstream stimulus stage for sequence_detect: serialises a loaded pattern word
//  MSB-first onto a single-bit stream x, one bit per clk, for 1..2^REP_W passes.
//  x connects directly to sequence_detect's x input, so test patterns are
//  generated in hardware rather than hand-written as delay chains.
// PARAMETERS
//  WIDTH  8  maximum pattern length in bits
//  LEN_W  4  width of len port (must hold WIDTH)
//  REP_W  4  width of reps port; passes = reps+1
// PORTS
//  clk      in   1      system clock, rising edge
//  reset    in   1      synchronous, active-high reset
//  start    in   1      begin a run (sampled in IDLE only)
//  stop     in   1      abort current run
//  hold     in   1      pause shifting; x frozen, x_valid low
//  pattern  in   WIDTH  bits to send; bit [eff_len-1] goes first
//  len      in   LEN_W  pattern length; 0 or >WIDTH clamps to WIDTH
//  reps     in   REP_W  extra passes after the first
//  x        out  1      serial bit to sequence_detect
//  x_valid  out  1      x carries a pattern bit this cycle
//  busy     out  1      run in progress (SHIFT state)
//  done     out  1      one-cycle pulse: run completed normally
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All state on clk rising edge.
//  - Reset: state=IDLE, x=0, x_valid=0, busy=0, done=0, all counters=0. Reset
//    mid-run aborts immediately and asserts no done.
//  - Registered outputs only; no combinational input->output path.
//  - States: IDLE, SHIFT.
//  - IDLE: edge with start=1 and stop=0 latches pattern, eff_len and reps. Same
//    edge: x<=pattern[eff_len-1], x_valid<=1, busy<=1, bit_idx<=eff_len-1,
//    pass_cnt<=reps, ->SHIFT. Latency: first bit is valid the cycle after start.
//    start with stop=1 is ignored.
//  - SHIFT, hold=0: each edge presents the next bit (bit_idx-1). When bit_idx==0:
//    if pass_cnt!=0, decrement pass_cnt, reload bit_idx=eff_len-1, present
//    bit[eff_len-1] with no gap cycle. Otherwise go IDLE: x<=0, x_valid<=0,
//    busy<=0, done<=1.
//  - SHIFT, hold=1: counters and x frozen; x_valid<=0; busy stays 1. The next
//    bit appears the edge after hold drops.
//  - stop=1 in SHIFT (overrides hold): ->IDLE, x<=0, x_valid<=0, busy<=0,
//    no done pulse.
//  - start while busy is ignored. Inputs are not re-sampled during a run.
//  - done is high exactly one cycle. An IDLE start on the cycle done is high
//    is accepted.
//  - Total valid bits per run = eff_len*(reps+1). The last bit stays on x for
//    its full cycle.
// STRUCTURE
//  - Shared include seq_gen_defs.vh: state encodings S_IDLE=1'b0, S_SHIFT=1'b1;
//    default WIDTH/LEN_W/REP_W.
//  - Natural sub-module: pgen_shift_reg, a WIDTH-bit loadable shift register
//    with shift-enable and an MSB tap at an index.
//  - Top level holds the FSM, bit_idx and pass_cnt counters, and output regs.
// TESTING (bench instantiates serial_pattern_gen -> sequence_detect)
//  1. pattern=8'b0001_1010, len=6, reps=0, start pulse -> x=0,1,1,0,1,0 on
//     6 consecutive cycles; done one cycle after the last bit; detector z as golden.
//  2. pattern=3'b101, len=3, reps=2 -> x=101101101 (9 valid cycles, no gaps),
//     busy high for 9 cycles, single done pulse.
//  3. len=0, pattern=8'hA5 -> 8 bits 1,0,1,0,0,1,0,1. len=12 -> same clamp.
//  4. hold high for 3 cycles after 2nd bit -> x_valid low 3 cycles, x frozen,
//     sequence resumes intact; total bit count unchanged.
//  5. stop on 4th bit -> IDLE next edge, busy=0, no done. reset on 4th bit ->
//     all outputs 0 next edge.
//  6. start re-pulsed while busy (different pattern) -> ignored; start on the
//     done cycle -> new run begins the next cycle.

Source files
------------

// File: rtl/serial_pattern_gen_pkg.sv
// serial_pattern_gen_pkg
//   Shared definitions for the serial pattern generator: FSM state encoding
//   and default sizing parameters.
//   No ports (package).
package serial_pattern_gen_pkg;

  localparam int DEF_WIDTH = 8;  // maximum pattern length in bits
  localparam int DEF_LEN_W = 4;  // width of len, must be able to hold DEF_WIDTH
  localparam int DEF_REP_W = 4;  // width of reps; passes = reps + 1

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_pattern_gen_shift_reg.sv
// pgen_shift_reg
//   WIDTH-bit loadable pattern register with an indexed tap. The pattern
//   stays put for the whole run; the bit index walks it instead. This lets a
//   pass restart with no gap cycle.
// Ports
//   clk      in   1      system clock, rising edge
//   reset    in   1      synchronous, active-high reset
//   load     in   1      capture d on this edge
//   d        in   WIDTH  pattern to capture
//   tap_idx  in   IDX_W  bit position to read
//   tap      out  1      selected bit (taken from d while loading)
module pgen_shift_reg #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [IDX_W-1:0] tap_idx,
  output logic             tap
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

  // Bypass on load so the first bit leaves on the same edge the pattern is captured.
  assign tap = load ? d[tap_idx] : q[tap_idx];

endmodule

// File: rtl/serial_pattern_gen.sv
// serial_pattern_gen
//   Serialises a loaded pattern word MSB-first onto x, one bit per clk, for
//   reps+1 back-to-back passes. Feeds sequence_detect's x input.
// Ports
//   clk      in   1      system clock, rising edge
//   reset    in   1      synchronous, active-high reset
//   start    in   1      begin a run (sampled in IDLE only)
//   stop     in   1      abort current run
//   hold     in   1      pause shifting; x frozen, x_valid low
//   pattern  in   WIDTH  bits to send; bit [eff_len-1] goes first
//   len      in   LEN_W  pattern length; 0 or >WIDTH clamps to WIDTH
//   reps     in   REP_W  extra passes after the first
//   x        out  1      serial bit
//   x_valid  out  1      x carries a pattern bit this cycle
//   busy     out  1      run in progress
//   done     out  1      one-cycle pulse on normal completion
//
// state   | meaning
// S_IDLE  | waiting for start; outputs low
// S_SHIFT | presenting pattern bits, pass_cnt passes still to go after this one
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state, state_n;
  logic [LEN_W-1:0] bit_idx, bit_idx_n;
  logic [LEN_W-1:0] eff_len, eff_len_n;
  logic [REP_W-1:0] pass_cnt, pass_n;
  logic             x_n, x_valid_n, busy_n, done_n;

  logic [LEN_W-1:0] eff_in;
  logic [LEN_W-1:0] tap_idx;
  logic             load;
  logic             tap;

  assign eff_in = ((len == '0) || (len > WIDTH_L)) ? WIDTH_L : len;
  assign load   = (state == S_IDLE) && start && !stop;

  // Index of the bit that goes out on the next edge: first bit of a new run,
  // the next lower bit, or the wrap back to the top for the next pass.
  always_comb begin
    tap_idx = eff_len - LEN_W'(1);
    if (state == S_IDLE) begin
      tap_idx = eff_in - LEN_W'(1);
    end else if (bit_idx != '0) begin
      tap_idx = bit_idx - LEN_W'(1);
    end
  end

  pgen_shift_reg #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .d       (pattern),
    .tap_idx (tap_idx[IDX_W-1:0]),
    .tap     (tap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      bit_idx  <= '0;
      eff_len  <= '0;
      pass_cnt <= '0;
      x        <= 1'b0;
      x_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_idx  <= bit_idx_n;
      eff_len  <= eff_len_n;
      pass_cnt <= pass_n;
      x        <= x_n;
      x_valid  <= x_valid_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_idx_n = bit_idx;
    eff_len_n = eff_len;
    pass_n    = pass_cnt;
    x_n       = x;
    x_valid_n = x_valid;
    busy_n    = busy;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        x_n       = 1'b0;
        x_valid_n = 1'b0;
        busy_n    = 1'b0;
        if (load) begin
          eff_len_n = eff_in;
          pass_n    = reps;
          bit_idx_n = eff_in - LEN_W'(1);
          x_n       = tap;
          x_valid_n = 1'b1;
          busy_n    = 1'b1;
          state_n   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (stop) begin
          x_n       = 1'b0;
          x_valid_n = 1'b0;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end else if (hold) begin
          x_valid_n = 1'b0;
        end else if (bit_idx != '0) begin
          bit_idx_n = bit_idx - LEN_W'(1);
          x_n       = tap;
          x_valid_n = 1'b1;
        end else if (pass_cnt != '0) begin
          pass_n    = pass_cnt - REP_W'(1);
          bit_idx_n = eff_len - LEN_W'(1);
          x_n       = tap;
          x_valid_n = 1'b1;
        end else begin
          x_n       = 1'b0;
          x_valid_n = 1'b0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
